// File: rtl/move_collector.sv
// move_collector: consumer end of the per-square move stacks.
// On start, walks squares 0..N_SQUARES-1 once and pops every queued move,
// streaming each move out on a valid/ready port. Then it pulses done.
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   start               begin a pass (sampled only while idle)
//   sq_empty, sq_move   per-square stack_empty / top-of-stack word
//   sq_read             per-square pop strobe (one-hot or zero)
//   move_out/_valid/_ready  collected-move stream
//   move_count, overflow    moves emitted this pass, sticky saturation flag
//   busy, done          not idle / one-cycle end-of-pass pulse
module move_collector #(
  parameter int N_SQUARES = 64,
  parameter int MOVE_W    = 16,
  parameter int CNT_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_SQUARES-1:0]          sq_empty,
  input  logic [N_SQUARES*MOVE_W-1:0]   sq_move,
  output logic [N_SQUARES-1:0]          sq_read,
  output logic [MOVE_W-1:0]             move_out,
  output logic                          move_valid,
  input  logic                          move_ready,
  output logic [CNT_W-1:0]              move_count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          done
);

  localparam int PTR_W = (N_SQUARES > 1) ? $clog2(N_SQUARES) : 1;
  localparam logic [PTR_W-1:0] LAST_SQ = PTR_W'(N_SQUARES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [N_SQUARES-1:0] sq_read_q, sq_read_d;
  logic [MOVE_W-1:0]   move_out_q, move_out_d;
  logic                move_valid_q, move_valid_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      ptr_q        <= '0;
      sq_read_q    <= '0;
      move_out_q   <= '0;
      move_valid_q <= 1'b0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      sq_read_q    <= sq_read_d;
      move_out_q   <= move_out_d;
      move_valid_q <= move_valid_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    sq_read_d    = '0;          // pop strobe lives for a single cycle
    move_out_d   = move_out_q;
    move_valid_d = move_valid_q;
    count_d      = count_q;
    overflow_d   = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d      = '0;
          count_d    = '0;
          overflow_d = 1'b0;
          state_d    = S_SCAN;
        end
      end

      S_SCAN: begin
        // sq_move is only looked at when the square reports a move, so an
        // undefined word on an empty square never reaches move_out.
        if (!sq_empty[ptr_q]) begin
          move_out_d   = sq_move[ptr_q*MOVE_W +: MOVE_W];
          sq_read_d    = N_SQUARES'(1) << ptr_q;
          move_valid_d = 1'b1;
          state_d      = S_HOLD;
        end else if (ptr_q == LAST_SQ) begin
          state_d = S_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end

      S_HOLD: begin
        // move_valid is always 1 here, so ready alone completes the handshake.
        // ptr stays put so the same square is drained until it reads empty;
        // the intervening SCAN cycle gives the stack time to update.
        if (move_ready) begin
          move_valid_d = 1'b0;
          if (count_q == CNT_MAX) begin
            overflow_d = 1'b1;
          end else begin
            count_d = count_q + 1'b1;
          end
          state_d = S_SCAN;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign sq_read    = sq_read_q;
  assign move_out   = move_out_q;
  assign move_valid = move_valid_q;
  assign move_count = count_q;
  assign overflow   = overflow_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);

endmodule
